// File: rtl/score_pkg.sv
// score_pkg: shared types and screen geometry for the score tracker.
//   NUM_KEYS  - piano keys tracked (one bit per key in a history row)
//   KEY_PX    - on-screen width of one key column in pixels
//   SCORE_X0  - X coordinate of the left edge of key 0
//   key_mask_t - one history row / live key bitmask
//   state_t    - tracker FSM states
package score_pkg;
    localparam int NUM_KEYS = 24;
    localparam int KEY_PX   = 20;
    localparam int SCORE_X0 = 160;

    typedef logic [NUM_KEYS-1:0] key_mask_t;

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;
endpackage

// File: rtl/score_tracker_if.sv
// score_tracker_if: pixel/key bus between the video front end and the
// score tracker.
//   frame_start - one-cycle pulse at the start of vertical blank
//   key_mask    - live key-held bitmask, bit k = key k
//   DrawX/DrawY - pixel currently being presented
//   score_q     - note-present bit for the pixel of the previous cycle
//   deltatime   - free-running frame counter
//   busy        - history buffer is being cleared
// master drives the pixel/key side, slave is the tracker.
interface score_tracker_if;
    import score_pkg::*;

    logic        frame_start;
    key_mask_t   key_mask;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        score_q;
    logic [12:0] deltatime;
    logic        busy;

    modport master (
        output frame_start, key_mask, DrawX, DrawY,
        input  score_q, deltatime, busy
    );

    modport slave (
        input  frame_start, key_mask, DrawX, DrawY,
        output score_q, deltatime, busy
    );
endinterface

// File: rtl/score_ram.sv
// score_ram: DEPTH x NUM_KEYS simple dual-port RAM.
//   clk     - clock
//   we      - write enable for wr_addr/wr_data
//   rd_addr - read address, data appears on rd_data one cycle later
// A read to the address being written returns the old contents.
module score_ram
    import score_pkg::*;
#(
    parameter int DEPTH = 128,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  key_mask_t     wr_data,
    input  logic [AW-1:0] rd_addr,
    output key_mask_t     rd_data
);
    key_mask_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/score_tracker.sv
// score_tracker: scrolling key-press history and per-pixel note lookup.
//   Clk   - pixel/system clock
//   Reset - synchronous active-high reset; restarts the buffer clear
//   bus   - score_tracker_if.slave (frame_start, key_mask, DrawX, DrawY in;
//           score_q, deltatime, busy out)
// Each scroll step stores the keys held (or briefly pressed) during the
// step as one row. For a pixel in the score area the row is selected by
// distance above the piano and the bit by key column; score_q follows one
// cycle later, matching the downstream ROM timing.
module score_tracker
    import score_pkg::*;
#(
    parameter int DEPTH        = 128,
    parameter int ROW_H        = 4,
    parameter int SCROLL_DIV   = 2,
    parameter int SCORE_BOTTOM = 360
) (
    input  logic Clk,
    input  logic Reset,
    score_tracker_if.slave bus
);
    localparam int AW       = $clog2(DEPTH);
    localparam int DW       = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam int RSH      = $clog2(ROW_H);
    localparam int KW       = $clog2(NUM_KEYS);
    localparam int SCORE_X1 = SCORE_X0 + KEY_PX * NUM_KEYS;

    state_t        state;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] clear_ptr;
    logic [DW-1:0] div_cnt;
    key_mask_t     accum;
    logic [12:0]   deltatime_r;
    logic          busy_r;
    logic          hit_q;
    logic [KW-1:0] key_q;

    logic          scroll;
    logic          ram_we;
    logic [AW-1:0] ram_wr_addr;
    key_mask_t     ram_wr_data;
    logic [AW-1:0] rd_addr;
    key_mask_t     rd_row;

    logic          in_area;
    logic [9:0]    y_off;
    logic [9:0]    age;
    logic          age_ok;
    logic [9:0]    x_off;
    logic [KW-1:0] key_idx;

    assign scroll = bus.frame_start && (state == RUN) && (div_cnt == DW'(SCROLL_DIV - 1));

    // Single write port shared by the clear sweep and scroll writes; the
    // row written includes this cycle's keys so a press on the scroll
    // cycle itself is not lost.
    always_comb begin
        ram_we      = 1'b0;
        ram_wr_addr = wr_ptr;
        ram_wr_data = accum | bus.key_mask;
        if (state == CLEAR) begin
            ram_we      = 1'b1;
            ram_wr_addr = clear_ptr;
            ram_wr_data = '0;
        end else if (scroll) begin
            ram_we      = 1'b1;
        end
    end

    // Pixel to (row, key). Newest row (wr_ptr-1) sits directly above the
    // piano, older rows further up. Out-of-area values of age/key are
    // meaningless and are masked by in_area.
    always_comb begin
        in_area = (bus.DrawY < 10'(SCORE_BOTTOM)) &&
                  (bus.DrawX >= 10'(SCORE_X0)) &&
                  (bus.DrawX < 10'(SCORE_X1));
        y_off   = 10'(SCORE_BOTTOM - 1) - bus.DrawY;
        age     = y_off >> RSH;
        age_ok  = {1'b0, age} < 11'(DEPTH);
        rd_addr = wr_ptr - AW'(1) - age[AW-1:0];
        x_off   = bus.DrawX - 10'(SCORE_X0);
        key_idx = KW'(x_off / 10'(KEY_PX));
    end

    score_ram #(.DEPTH(DEPTH)) u_ram (
        .clk     (Clk),
        .we      (ram_we),
        .wr_addr (ram_wr_addr),
        .wr_data (ram_wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_row)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= CLEAR;
            wr_ptr      <= '0;
            clear_ptr   <= '0;
            div_cnt     <= '0;
            accum       <= '0;
            deltatime_r <= '0;
            busy_r      <= 1'b1;
            hit_q       <= 1'b0;
            key_q       <= '0;
        end else begin
            if (bus.frame_start)
                deltatime_r <= deltatime_r + 13'd1;

            // Qualifiers travel alongside the RAM read so the bit select
            // lines up with rd_row.
            hit_q <= in_area && !busy_r && age_ok;
            key_q <= key_idx;

            case (state)
                CLEAR: begin
                    clear_ptr <= clear_ptr + AW'(1);
                    if (clear_ptr == AW'(DEPTH - 1)) begin
                        state  <= RUN;
                        busy_r <= 1'b0;
                    end
                end
                RUN: begin
                    if (scroll) begin
                        wr_ptr  <= wr_ptr + AW'(1);
                        div_cnt <= '0;
                        accum   <= '0;
                    end else begin
                        accum <= accum | bus.key_mask;
                        if (bus.frame_start)
                            div_cnt <= div_cnt + DW'(1);
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    assign bus.score_q   = hit_q & rd_row[key_q];
    assign bus.deltatime = deltatime_r;
    assign bus.busy      = busy_r;
endmodule

// File: tb/tb_score_tracker.sv
module tb_score_tracker;
    import score_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    logic [12:0] exp_dt = '0;

    score_tracker_if bus();

    score_tracker dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one frame_start pulse plus one idle cycle
    task automatic pulse();
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
        tick();
        exp_dt = exp_dt + 13'd1;
    endtask

    // present a pixel; score_q for it is valid after the next edge
    task automatic look(input int x, input int y);
        bus.DrawX = 10'(x);
        bus.DrawY = 10'(y);
        tick();
    endtask

    task automatic test_reset();
        int n;
        int sq_bad;
        rst = 1'b1;
        bus.DrawX = 10'd165;
        bus.DrawY = 10'd359;
        repeat (3) tick();
        total++;
        if (bus.busy !== 1'b1 || bus.deltatime !== 13'd0 || bus.score_q !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: busy=%0b dt=%0d score_q=%0b, required 1/0/0",
                     bus.busy, bus.deltatime, bus.score_q);
        end
        rst = 1'b0;
        n = 0;
        sq_bad = 0;
        while (bus.busy === 1'b1 && n < 300) begin
            tick();
            n++;
            if (bus.score_q !== 1'b0) sq_bad++;
        end
        total++;
        if (n != 128) begin
            bad++;
            $display("FAIL clear_len: busy cycles=%0d, required 128", n);
        end
        total++;
        if (sq_bad != 0) begin
            bad++;
            $display("FAIL clear_score: score_q high %0d cycles, required 0", sq_bad);
        end
        total++;
        if (bus.deltatime !== 13'd0) begin
            bad++;
            $display("FAIL clear_dt: deltatime=%0d, required 0", bus.deltatime);
        end
    endtask

    task automatic test_single_key();
        int xs [4] = '{165, 185, 165, 165};
        int ys [4] = '{359, 359, 355, 356};
        bit ex [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        bus.key_mask = 24'h000001;
        pulse();
        // scroll cycle: key still held, release right after
        bus.frame_start = 1'b1;
        tick();
        bus.key_mask = '0;
        bus.frame_start = 1'b0;
        tick();
        exp_dt = exp_dt + 13'd1;
        for (int i = 0; i < 4; i++) begin
            look(xs[i], ys[i]);
            total++;
            if (bus.score_q !== ex[i]) begin
                bad++;
                $display("FAIL single_key (%0d,%0d): score_q=%0b, required %0b",
                         xs[i], ys[i], bus.score_q, ex[i]);
            end
        end
    endtask

    task automatic test_short_press();
        int xs [5] = '{635, 640, 639, 165, 165};
        int ys [5] = '{357, 357, 357, 359, 355};
        bit ex [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        pulse();
        bus.key_mask = 24'h800000;
        tick();
        bus.key_mask = '0;
        tick();
        pulse();
        for (int i = 0; i < 5; i++) begin
            look(xs[i], ys[i]);
            total++;
            if (bus.score_q !== ex[i]) begin
                bad++;
                $display("FAIL short_press (%0d,%0d): score_q=%0b, required %0b",
                         xs[i], ys[i], bus.score_q, ex[i]);
            end
        end
    endtask

    task automatic test_age();
        int xs [6] = '{260, 279, 259, 280, 260, 260};
        int ys [6] = '{320, 323, 321, 322, 324, 319};
        bit ex [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        bus.key_mask = 24'h000020;
        pulse();
        bus.frame_start = 1'b1;
        tick();
        bus.key_mask = '0;
        bus.frame_start = 1'b0;
        tick();
        exp_dt = exp_dt + 13'd1;
        repeat (18) pulse();
        for (int i = 0; i < 6; i++) begin
            look(xs[i], ys[i]);
            total++;
            if (bus.score_q !== ex[i]) begin
                bad++;
                $display("FAIL age (%0d,%0d): score_q=%0b, required %0b",
                         xs[i], ys[i], bus.score_q, ex[i]);
            end
        end
    endtask

    task automatic test_deltatime();
        total++;
        if (bus.deltatime !== exp_dt) begin
            bad++;
            $display("FAIL dt_count: deltatime=%0d, required %0d", bus.deltatime, exp_dt);
        end
        while (exp_dt != 13'd8191) pulse();
        total++;
        if (bus.deltatime !== 13'd8191) begin
            bad++;
            $display("FAIL dt_max: deltatime=%0d, required 8191", bus.deltatime);
        end
        pulse();
        total++;
        if (bus.deltatime !== 13'd0) begin
            bad++;
            $display("FAIL dt_wrap: deltatime=%0d, required 0", bus.deltatime);
        end
    endtask

    task automatic test_reset_mid_run();
        int n;
        int zbad;
        int ys [3] = '{359, 300, 100};
        bus.key_mask = 24'hFFFFFF;
        pulse();
        pulse();
        bus.key_mask = '0;
        look(165, 359);
        total++;
        if (bus.score_q !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_row: score_q=%0b, required 1", bus.score_q);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_dt = '0;
        total++;
        if (bus.busy !== 1'b1 || bus.deltatime !== 13'd0 || bus.score_q !== 1'b0) begin
            bad++;
            $display("FAIL rerun_reset: busy=%0b dt=%0d score_q=%0b, required 1/0/0",
                     bus.busy, bus.deltatime, bus.score_q);
        end
        // a frame pulse during the clear must bump deltatime only
        n = 0;
        while (bus.busy === 1'b1 && n < 300) begin
            bus.frame_start = (n == 10);
            tick();
            n++;
        end
        bus.frame_start = 1'b0;
        exp_dt = exp_dt + 13'd1;
        total++;
        if (n != 128) begin
            bad++;
            $display("FAIL reclear_len: busy cycles=%0d, required 128", n);
        end
        total++;
        if (bus.deltatime !== exp_dt) begin
            bad++;
            $display("FAIL reclear_dt: deltatime=%0d, required %0d", bus.deltatime, exp_dt);
        end
        zbad = 0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            for (int j = 0; j < 3; j++) begin
                look(SCORE_X0 + KEY_PX * k + 10, ys[j]);
                if (bus.score_q !== 1'b0) zbad++;
            end
        end
        total++;
        if (zbad != 0) begin
            bad++;
            $display("FAIL post_reset_zero: %0d pixels set, required 0", zbad);
        end
        bus.key_mask = 24'h000001;
        pulse();
        look(165, 359);
        total++;
        if (bus.score_q !== 1'b0) begin
            bad++;
            $display("FAIL clear_div_hold: score_q=%0b after first pulse, required 0", bus.score_q);
        end
        pulse();
        bus.key_mask = '0;
        look(165, 359);
        total++;
        if (bus.score_q !== 1'b1) begin
            bad++;
            $display("FAIL post_reset_scroll: score_q=%0b, required 1", bus.score_q);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.frame_start = 1'b0;
        bus.key_mask = '0;
        bus.DrawX = '0;
        bus.DrawY = '0;
        test_reset();
        test_single_key();
        test_short_press();
        test_age();
        test_deltatime();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
